// File: rtl/demux_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : demux_dispatch_ctrl
// Purpose  : Round-robin dispatcher driving the select/valid of a 1-to-8 demux.
// Revision : 1.0  initial release
// ============================================================================
module demux_dispatch_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [7:0]        en_mask,
  input  logic [7:0]        out_ready,
  output logic [7:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        sel,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t             r_state;
  logic [2:0]         r_ptr;
  logic [2:0]         r_sel;
  logic               r_in_ready;
  logic               r_busy;
  logic [7:0]         r_out_valid;
  logic [DATA_W-1:0]  r_hold;
  logic [CNT_W-1:0]   r_drop_cnt;

  logic [7:0]         w_elig;
  logic [2:0]         w_idx;
  logic [2:0]         w_pick;
  logic               w_found;

  assign w_elig = en_mask & out_ready;

  // Scan from the highest offset down so the channel closest to r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = r_ptr;
    for (int i = 7; i >= 0; i--) begin
      w_idx = r_ptr + 3'(i);
      if (w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 3'd0;
      r_sel       <= 3'd0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 8'd0;
      r_hold      <= '0;
      r_drop_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_hold     <= in_data;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_ARB;
          end else begin
            // First cycle after reset release lands here with in_ready low.
            r_in_ready <= 1'b1;
          end
        end
        ST_ARB: begin
          if (en_mask == 8'd0) begin
            r_hold     <= '0;
            if (r_drop_cnt != {CNT_W{1'b1}}) begin
              r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (w_found) begin
            r_sel       <= w_pick;
            r_out_valid <= 8'd1 << w_pick;
            r_state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready[r_sel]) begin
            r_ptr       <= r_sel + 3'd1;
            r_out_valid <= 8'd0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 8'd0;
          r_in_ready  <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_hold;
  assign sel       = r_sel;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_dispatch_ctrl.sv
`default_nettype none
// Scoreboard bench for demux_dispatch_ctrl: directed scenarios plus a random phase,
// checked against a transaction-level reference model of the dispatch rules.
module tb_demux_dispatch_ctrl;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [7:0]        en_mask = 8'h00;
  logic [7:0]        out_ready = 8'h00;
  logic              in_ready;
  logic [7:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        sel;
  logic              busy;
  logic [CNT_W-1:0]  drop_cnt;

  demux_dispatch_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .en_mask(en_mask), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .sel(sel), .busy(busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit rand_on  = 1'b0;

  logic [7:0] sb_q[$];     // words accepted and not yet delivered or dropped
  int         exp_ch_q[$]; // channel the model expects the pending word to use
  int         dlv_q[$];    // channels on which transfers completed
  int         acc_q[$];    // cycle numbers of accepts

  // Reference model state
  int m_ptr  = 0;
  int m_ch   = -1;
  bit m_pend = 1'b0;
  int m_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired, got no response, expected one (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc++;

  // Reference model: at each falling edge compare status outputs for the current
  // cycle, then apply the rules for the upcoming rising edge.
  always @(negedge clk) begin
    int c;
    if (!rst_n) begin
      m_ptr = 0; m_ch = -1; m_pend = 1'b0; m_drop = 0;
      sb_q.delete(); exp_ch_q.delete();
    end else begin
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("busy", 32'(busy), 32'(m_pend || m_ch >= 0));
      chk("in_ready", 32'(in_ready), 32'(!(m_pend || m_ch >= 0)));
      if (m_ch < 0) chk("out_valid_quiet", 32'(out_valid), 32'd0);
      if (m_ch >= 0) begin
        if (out_ready[m_ch]) begin
          m_ptr = (m_ch + 1) % 8;
          m_ch  = -1;
        end
      end else if (m_pend) begin
        if (en_mask == 8'h00) begin
          m_pend = 1'b0;
          if (m_drop < 255) m_drop++;
          if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
          for (int k = 0; k < 8; k++) begin
            c = (m_ptr + k) % 8;
            if (m_ch < 0 && en_mask[c] && out_ready[c]) begin
              m_ch   = c;
              m_pend = 1'b0;
              exp_ch_q.push_back(c);
            end
          end
        end
      end else if (in_valid && in_ready) begin
        m_pend = 1'b1;
      end
    end
  end

  // Monitor: whenever the DUT presents a word, compare against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid != 8'h00) begin
      if (exp_ch_q.size() == 0 || sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out_valid: got out_valid=0x%0h, expected none pending (t=%0t)",
                 out_valid, $time);
      end else begin
        chk("out_valid", 32'(out_valid), 32'(1) << exp_ch_q[0]);
        chk("sel", 32'(sel), 32'(exp_ch_q[0]));
        chk("out_data", 32'(out_data), 32'(sb_q[0]));
        if (out_ready[exp_ch_q[0]]) begin
          dlv_q.push_back(exp_ch_q[0]);
          void'(exp_ch_q.pop_front());
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // Random consumer/enable behaviour for the soak phase.
  always @(posedge clk) begin
    if (rand_on) begin
      #1;
      out_ready = 8'($urandom);
      if ($urandom_range(0, 9) == 0) en_mask = 8'h00;
      else if ($urandom_range(0, 3) == 0) en_mask = 8'($urandom);
    end
  end

  task automatic send_word(input logic [7:0] d);
    int t = 0;
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      t++;
    end
    if (ok) begin
      sb_q.push_back(d);
      acc_q.push_back(cyc);
    end else begin
      fail_now("accept_timeout");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    bit ok = 1'b0;
    while (!ok && t < 300) begin
      @(negedge clk);
      if (in_ready && out_valid == 8'h00) ok = 1'b1;
      t++;
    end
    if (!ok) fail_now("idle_timeout");
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset, released just after a falling edge.
    repeat (2) @(negedge clk);
    #1;
    chk("por_in_ready", 32'(in_ready), 32'd0);
    chk("por_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back words with every channel enabled and ready.
    en_mask = 8'hFF; out_ready = 8'hFF;
    dlv_q.delete(); acc_q.delete();
    for (int i = 0; i < 9; i++) send_word(8'hA0 + 8'(i));
    wait_idle();
    chk("t2_count", 32'(dlv_q.size()), 32'd9);
    if (dlv_q.size() == 9)
      for (int i = 0; i < 9; i++) chk("t2_channel", 32'(dlv_q[i]), 32'(i % 8));
    for (int i = 1; i < acc_q.size(); i++) chk("t2_period", 32'(acc_q[i] - acc_q[i-1]), 32'd3);

    // Sparse enable mask starting from pointer 0.
    do_reset();
    en_mask = 8'b0010_0100; out_ready = 8'hFF;
    dlv_q.delete();
    for (int i = 0; i < 3; i++) send_word(8'h30 + 8'(i));
    wait_idle();
    chk("t3_count", 32'(dlv_q.size()), 32'd3);
    if (dlv_q.size() == 3) begin
      chk("t3_ch0", 32'(dlv_q[0]), 32'd2);
      chk("t3_ch1", 32'(dlv_q[1]), 32'd5);
      chk("t3_ch2", 32'(dlv_q[2]), 32'd2);
    end

    // Pointer at 3 with channel 3 busy, then a stalled consumer on channel 4.
    do_reset();
    en_mask = 8'hFF; out_ready = 8'hFF;
    for (int i = 0; i < 3; i++) send_word(8'h10 + 8'(i));
    wait_idle();
    dlv_q.delete();
    out_ready = 8'hF7;
    send_word(8'h4C);
    @(posedge clk); #1;
    out_ready = 8'hE7;
    repeat (4) @(posedge clk);
    #1;
    out_ready = 8'hFF;
    wait_idle();
    chk("t4_count", 32'(dlv_q.size()), 32'd1);
    if (dlv_q.size() == 1) chk("t4_ch", 32'(dlv_q[0]), 32'd4);

    // No consumer ready: wait in arbitration, then only channel 6 comes up.
    out_ready = 8'h00;
    dlv_q.delete();
    send_word(8'h66);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    out_ready = 8'h40;
    @(negedge clk);
    @(negedge clk);
    chk("t6_send_valid", 32'(out_valid), 32'h40);
    chk("t6_send_sel", 32'(sel), 32'd6);
    wait_idle();
    chk("t6_count", 32'(dlv_q.size()), 32'd1);

    // Drops with no channel enabled, including counter saturation.
    en_mask = 8'h00; out_ready = 8'hFF;
    send_word(8'hD0);
    @(negedge clk);
    chk("t5_in_ready_arb", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t5_in_ready_back", 32'(in_ready), 32'd1);
    chk("t5_drop_one", 32'(drop_cnt), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) send_word(8'(i));
    wait_idle();
    chk("t5_drop_sat", 32'(drop_cnt), 32'd255);

    // Reset in the middle of a transfer on channel 7.
    en_mask = 8'hFF; out_ready = 8'hFF;
    send_word(8'h77);
    @(posedge clk); #1;
    out_ready = 8'h00;
    @(negedge clk);
    chk("t1_pre_valid", 32'(out_valid), 32'h80);
    do_reset();
    out_ready = 8'hFF;
    dlv_q.delete();
    send_word(8'h5A);
    wait_idle();
    chk("t1_post_count", 32'(dlv_q.size()), 32'd1);
    if (dlv_q.size() == 1) chk("t1_post_ch", 32'(dlv_q[0]), 32'd0);

    // Random soak.
    rand_on = 1'b1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_word(8'($urandom));
    end
    rand_on = 1'b0;
    @(posedge clk); #2;
    en_mask = 8'hFF; out_ready = 8'hFF;
    wait_idle();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
